// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Imported by the byte packer and the loader top level.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic is_terminal(state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host/memory side.
interface instruction_loader_if #(
    parameter int ADDR_W = 32
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes.
// Used for both the header word and every payload word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST =
        IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_shift;

    // Bytes enter at the top so byte 0 ends up in bits [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_en) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= {i_byte, r_shift[31:8]};
        end
    end

    assign o_word_valid = i_en && (r_idx == LAST);
    assign o_word       = {i_byte, r_shift[31:8]};

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: byte stream -> header/payload/checksum -> instruction
// memory writes, holding the CPU stalled while the load runs.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    instruction_loader_if.master bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t r_state;
    state_t w_next;

    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_error;
    logic             w_accept;
    logic             w_start;
    logic             w_pack_en;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic             w_last_word;

    logic [31:0]       r_cnt;
    logic [CNT_W-1:0]  r_k;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [7:0]        r_xor;

    assign w_accept  = bus.byte_valid && w_ready;
    assign w_start   = start && is_terminal(r_state);
    assign w_pack_en = w_accept &&
                       ((r_state == HEADER) ||
                        (r_state == DATA));
    assign w_last_word =
        ((32'(r_k) + 32'd1) == r_cnt);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start),
        .i_en         (w_pack_en),
        .i_byte       (bus.byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) w_next = HEADER;
            end
            HEADER: begin
                if (w_word_valid) begin
                    if (w_word == 32'd0)
                        w_next = CHECK;
                    else if (w_word > DEPTH_W)
                        w_next = ERROR;
                    else
                        w_next = DATA;
                end
            end
            DATA: begin
                if (w_word_valid && w_last_word)
                    w_next = CHECK;
            end
            CHECK: begin
                if (w_accept)
                    w_next = (bus.byte_data == r_xor) ?
                             DONE : ERROR;
            end
            default: w_next = IDLE;
        endcase
    end

    // Status is decoded straight from the state register.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_error = 1'b0;
        unique case (r_state)
            HEADER, DATA, CHECK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            DONE:    w_done  = 1'b1;
            ERROR:   w_error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_k     <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_xor   <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_k   <= '0;
                r_xor <= '0;
            end
            if (r_state == HEADER && w_word_valid)
                r_cnt <= w_word;
            if (r_state == DATA && w_accept)
                r_xor <= r_xor ^ bus.byte_data;
            if (r_state == DATA && w_word_valid) begin
                r_we    <= 1'b1;
                r_addr  <= ADDR_W'({r_k, 2'b00});
                r_wdata <= w_word;
                r_k     <= r_k + 1'b1;
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign busy           = w_busy;
    assign cpu_hold       = w_busy;
    assign done           = w_done;
    assign error          = w_error;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the processor's instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially from byte address 0 into the memory's write port. While a load is in progress it holds the CPU stalled. When the load ends it reports done or error. It sits between the host/UART byte source and the instruction memory.

## Interface
Parameters:
- DEPTH, 1024: instruction memory size in 32-bit words.
- ADDR_W, 32: width of the memory address (byte address).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load.
- byte_valid  in  1  source has a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte this cycle.
- mem_we  out  1  write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address, always word-aligned.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  stall/reset request to the CPU.
- busy  out  1  load in progress.
- done  out  1  sticky; last load succeeded.
- error  out  1  sticky; last load failed.

## Operation
- A byte is accepted on any edge where byte_valid && byte_ready.
- Stream format:
  - 4-byte header: word count N, little-endian.
  - N×4 payload bytes: each word little-endian, byte 0 = bits [7:0].
  - 1 trailer byte: XOR of all payload bytes.
- FSM states and transitions:
  - IDLE: start → HEADER. Clears done/error and the checksum.
  - HEADER: after the 4th byte, N=0 → CHECK; N>DEPTH → ERROR; otherwise → DATA.
  - DATA: each 4th byte completes a word. The word is written at mem_addr = 4·k, with k = 0..N−1. After word N−1 → CHECK.
  - CHECK: one byte accepted. If it equals the running XOR → DONE, else → ERROR.
  - DONE / ERROR: terminal. start → HEADER (restart).
- Header byte values beyond bit 10 count toward the N>DEPTH check; full 32-bit compare.
- start is ignored while busy.
- The checksum covers payload bytes only. The header and trailer bytes are excluded.

## Timing
- Reset values:
  - state=IDLE.
  - byte_ready, mem_we, busy, done, error and cpu_hold are all 0.
  - mem_addr and mem_wdata are 0.
- byte_ready is combinational from state: 1 in HEADER, DATA and CHECK, else 0. It never depends on byte_valid.
- Write latency: mem_we pulses high for exactly one cycle, on the cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are registered and stable during that cycle.
- Streaming back-to-back at one byte per cycle is fully supported; no stalls are inserted.
- busy and cpu_hold go to 1 on the cycle after start is sampled in IDLE/DONE/ERROR. They drop to 0 on the same edge that done or error rises.
- The final word's mem_we strictly precedes the CHECK-state byte acceptance.
- The word counter wraps never. The N>DEPTH rejection guarantees mem_addr ≤ 4·(DEPTH−1).
- Gaps (byte_valid low) hold all state, with no timeout.
- Asynchronous reset mid-load immediately returns to IDLE with all outputs at their reset values. Memory contents already written are not rolled back.
- ERROR reached from HEADER accepts no further bytes. Remaining source bytes are left unconsumed.

## Structure
- loader_pkg holds:
  - the state enum (IDLE, HEADER, DATA, CHECK, DONE, ERROR);
  - HDR_BYTES=4;
  - BYTES_PER_WORD=4.
- Sub-module byte_packer holds the 2-bit byte index and a 32-bit shift/assembly register. It emits word_valid and word for one cycle on each 4th byte. It is reused for both header and payload and cleared on start.
- Top level holds the FSM, word counter, address register, XOR accumulator and status flags.

## Test plan
- Load of 3 words:
  - Stimulus: N=3, payload words 0xE3A01A01, 0xE3A00014, 0xEAFFFFFF, correct trailer.
  - Required: three mem_we pulses at addresses 0, 4, 8 carrying those exact values, then done=1, error=0, cpu_hold=0.
- Bad checksum: N=1, word 0x12345678, trailer 0x00 (correct value is 0x08) → one write, then error=1, done=0.
- Oversize header: N=1025 → no mem_we, error=1 right after the 4th header byte, byte_ready=0.
- Empty image with gaps: N=0, trailer 0x00, byte_valid toggled 1/0 every cycle → done=1 with zero writes.
- Reset mid-load: rst asserted after 6 payload bytes → all outputs are 0 on the next sample. A fresh start followed by a full 1-word image then succeeds at address 0.
- start while busy is ignored; start after DONE restarts the load and clears done within 1 cycle.
